// File: rtl/rtc_bus_responder.sv
// -----------------------------------------------------------------------------
// rtc_bus_responder
//
// Purpose:
//    Slave responder for a multiplexed address/data controller bus that fronts
//    a 16 x 8 register file (addresses 0x00-0x0F). An address phase loads the
//    latched address. A data phase either writes the addressed register or
//    returns its contents on AdressDatao. Addresses 0x10-0xFF read back as 0x00
//    and ignore writes. The latched address is kept between transactions and
//    never auto-increments.
//
// Optional feature (compile-time macro RTC_RESPONDER_TICK_EN):
//    When defined, a divider produces a one-second tick every TICK_DIV clocks.
//    Each tick BCD-increments register 0x00 (seconds, 0x59 -> 0x00). On the
//    wrap it BCD-increments register 0x01 (minutes, 0x59 -> 0x00, no hour
//    carry). A bus write to 0x00/0x01 beats a simultaneous tick for that
//    register and restarts the divider. When undefined, no divider exists and
//    registers change only through bus writes.
//
// Ports:
//    clock         in   1  system clock, all logic on the rising edge
//    reset         in   1  synchronous, active-high reset
//    CS            in   1  chip select, active-low
//    AD            in   1  phase select: 0 = address phase, 1 = data phase
//    WR            in   1  write strobe, active-low
//    RD            in   1  read strobe, active-low
//    AdressDatai   in   8  multiplexed address/data from the controller
//    AdressDatao   out  8  read data (0x00 outside READ)
//    data_oe       out  1  high exactly while the FSM is in READ
//    addr_latched  out  8  most recently committed address
//    rstate        out  2  FSM state code (IDLE=0, ADDR=1, WRITE=2, READ=3)
// -----------------------------------------------------------------------------
module rtc_bus_responder #(
   parameter int unsigned TICK_DIV = 100
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       CS,
   input  logic       AD,
   input  logic       WR,
   input  logic       RD,
   input  logic [7:0] AdressDatai,
   output logic [7:0] AdressDatao,
   output logic       data_oe,
   output logic [7:0] addr_latched,
   output logic [1:0] rstate
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_WRITE = 2'd2,
      ST_READ  = 2'd3
   } state_e;

   // A zero divider would make the tick comparison meaningless.
   if (TICK_DIV < 32'd1) begin : g_tick_div_check
      $error("rtc_bus_responder: TICK_DIV must be at least 1");
   end

   // Registered copies of the bus; the FSM looks only at these.
   logic       cs_q;
   logic       ad_q;
   logic       wr_q;
   logic       rd_q;
   logic [7:0] bus_q;

   state_e     state_q;
   state_e     state_d;
   logic [7:0] cap_q;
   logic [7:0] cap_d;
   logic [7:0] addr_q;
   logic [7:0] addr_d;
   logic [7:0] regs_q      [16];
   logic [7:0] regs_d      [16];
   logic [7:0] regs_tick_s [16];
   logic [7:0] dout_q;
   logic [7:0] dout_d;
   logic       oe_q;
   logic       oe_d;

   logic       commit_s;
   logic       commit_addr_s;
   logic       commit_reg_s;

   // Sample the controller bus once; idle values on reset so nothing starts.
   always_ff @(posedge clock) begin
      if (reset) begin
         cs_q  <= 1'b1;
         ad_q  <= 1'b0;
         wr_q  <= 1'b1;
         rd_q  <= 1'b1;
         bus_q <= 8'h00;
      end else begin
         cs_q  <= CS;
         ad_q  <= AD;
         wr_q  <= WR;
         rd_q  <= RD;
         bus_q <= AdressDatai;
      end
   end

   // FSM next state, bus capture and commit decision.
   always_comb begin
      state_d  = state_q;
      cap_d    = cap_q;
      commit_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // RD and WR low together is illegal and ignored.
            if (!cs_q && !(!wr_q && !rd_q)) begin
               if (!wr_q) begin
                  cap_d = bus_q;
                  if (ad_q) begin
                     state_d = ST_WRITE;
                  end else begin
                     state_d = ST_ADDR;
                  end
               end else if (!rd_q && ad_q) begin
                  state_d = ST_READ;
               end else begin
                  // RD low during an address phase is illegal.
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADDR, ST_WRITE: begin
            // WR high commits even if CS rose in the same cycle; CS high
            // with WR still low abandons the phase.
            if (wr_q) begin
               commit_s = 1'b1;
               state_d  = ST_IDLE;
            end else if (cs_q) begin
               state_d  = ST_IDLE;
            end else begin
               cap_d    = bus_q;
               state_d  = state_q;
            end
         end
         ST_READ: begin
            if (rd_q || cs_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_READ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign commit_addr_s = commit_s && (state_q == ST_ADDR);
   assign commit_reg_s  = commit_s && (state_q == ST_WRITE) && (addr_q[7:4] == 4'h0);

`ifdef RTC_RESPONDER_TICK_EN
   localparam int unsigned   DIV_W    = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 32'd1);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic             tick_s;
   logic             rtc_wr_s;

   // BCD increment within 00..59; 0x59 wraps to 0x00.
   function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h59) begin
         r = 8'h00;
      end else if (v[3:0] >= 4'h9) begin
         r = {v[7:4] + 4'h1, 4'h0};
      end else begin
         r = {v[7:4], v[3:0] + 4'h1};
      end
      return r;
   endfunction

   assign tick_s   = (div_q == DIV_LAST);
   assign rtc_wr_s = commit_reg_s && (addr_q[7:1] == 7'h00);

   // Apply the tick to seconds/minutes; a bus write later overrides it.
   always_comb begin
      regs_tick_s = regs_q;
      if (tick_s) begin
         regs_tick_s[0] = bcd_inc59(regs_q[0]);
         if (regs_q[0] == 8'h59) begin
            regs_tick_s[1] = bcd_inc59(regs_q[1]);
         end else begin
            regs_tick_s[1] = regs_q[1];
         end
      end else begin
         regs_tick_s[0] = regs_q[0];
      end
   end

   // Divider restarts on each tick and on any bus write to the time registers.
   always_comb begin
      if (rtc_wr_s || tick_s) begin
         div_d = {DIV_W{1'b0}};
      end else begin
         div_d = div_q + DIV_W'(1'b1);
      end
   end

   // Divider register.
   always_ff @(posedge clock) begin
      if (reset) begin
         div_q <= {DIV_W{1'b0}};
      end else begin
         div_q <= div_d;
      end
   end
`else
   assign regs_tick_s = regs_q;
`endif

   // Address latch and register file next state; bus write has last word.
   always_comb begin
      if (commit_addr_s) begin
         addr_d = cap_q;
      end else begin
         addr_d = addr_q;
      end
      for (int i = 0; i < 16; i++) begin
         if (commit_reg_s && (addr_q[3:0] == 4'(i))) begin
            regs_d[i] = cap_q;
         end else begin
            regs_d[i] = regs_tick_s[i];
         end
      end
   end

   // Read port follows the next-cycle state so it lines up with data_oe and
   // sees a write committed on the cycle the read begins.
   always_comb begin
      oe_d = (state_d == ST_READ);
      if ((state_d == ST_READ) && (addr_d[7:4] == 4'h0)) begin
         dout_d = regs_d[addr_d[3:0]];
      end else begin
         dout_d = 8'h00;
      end
   end

   // State, capture, address, register file and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cap_q   <= 8'h00;
         addr_q  <= 8'h00;
         dout_q  <= 8'h00;
         oe_q    <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         oe_q    <= oe_d;
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign AdressDatao  = dout_q;
   assign data_oe      = oe_q;
   assign addr_latched = addr_q;
   assign rstate       = state_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_responder
//
// Directed bench for rtc_bus_responder. A table of one-cycle bus vectors with
// hand-computed outputs covers address, write, read, out-of-range and
// illegal-strobe cases. Hand-written sequences cover abort, CS/WR
// simultaneous rise, reset during READ and, when RTC_RESPONDER_TICK_EN is
// defined, the seconds/minutes roll-over.
// Inputs change on the falling edge; outputs are compared on the next falling
// edge.
// -----------------------------------------------------------------------------
module tb_rtc_bus_responder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       CS    = 1'b1;
   logic       AD    = 1'b0;
   logic       WR    = 1'b1;
   logic       RD    = 1'b1;
   logic [7:0] AdressDatai = 8'h00;
   logic [7:0] AdressDatao;
   logic       data_oe;
   logic [7:0] addr_latched;
   logic [1:0] rstate;

   int n_pass  = 0;
   int n_total = 0;

`ifdef RTC_RESPONDER_TICK_EN
   // Registers 0x00/0x01 advance on their own in this build.
   localparam int FIRST_CHK = 2;
`else
   localparam int FIRST_CHK = 0;
`endif

   logic [7:0] m_regs [16];

   typedef struct packed {
      logic       cs;
      logic       ad;
      logic       wr;
      logic       rd;
      logic [7:0] bus;
      logic [1:0] st;
      logic       oe;
      logic [7:0] dout;
      logic [7:0] addr;
   } vec_t;

   localparam int NVEC = 25;
   vec_t vecs [NVEC];

   rtc_bus_responder #(.TICK_DIV(10)) dut (
      .clock        (clock),
      .reset        (reset),
      .CS           (CS),
      .AD           (AD),
      .WR           (WR),
      .RD           (RD),
      .AdressDatai  (AdressDatai),
      .AdressDatao  (AdressDatao),
      .data_oe      (data_oe),
      .addr_latched (addr_latched),
      .rstate       (rstate)
   );

   always #5 clock = ~clock;

   function automatic vec_t mk(input logic cs, input logic ad, input logic wr,
                               input logic rd, input logic [7:0] bus,
                               input logic [1:0] st, input logic oe,
                               input logic [7:0] dout, input logic [7:0] addr);
      vec_t v;
      v.cs = cs; v.ad = ad; v.wr = wr; v.rd = rd; v.bus = bus;
      v.st = st; v.oe = oe; v.dout = dout; v.addr = addr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   // One bus cycle: drive after a falling edge, return on the next one.
   task automatic cyc(input logic cs, input logic ad, input logic wr,
                      input logic rd, input logic [7:0] bus);
      CS = cs; AD = ad; WR = wr; RD = rd; AdressDatai = bus;
      @(negedge clock);
   endtask

   task automatic set_addr(input logic [7:0] a);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, a);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, a);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
      chk($sformatf("addr_latched after addr phase 0x%02h", a), addr_latched, a);
   endtask

   task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
      set_addr(a);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, d);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, d);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
   endtask

   task automatic read_reg(input logic [7:0] a, input logic [7:0] exp);
      set_addr(a);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      chk($sformatf("read data reg 0x%02h", a), AdressDatao, exp);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
   endtask

   task automatic read_all();
      for (int a = FIRST_CHK; a < 16; a++) begin
         read_reg(8'(a), m_regs[a]);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

      //              cs    ad    wr    rd    bus     st    oe    dout   addr
      vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 2'd0, 1'b0, 8'h00, 8'h00);
      vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 2'd1, 1'b0, 8'h00, 8'h00);
      vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 2'd1, 1'b0, 8'h00, 8'h00);
      vecs[3]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 2'd1, 1'b0, 8'h00, 8'h00);
      vecs[4]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0, 8'h00, 8'h03);
      // write 0xA5 to 0x03, read starting the cycle after the commit
      vecs[5]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 2'd0, 1'b0, 8'h00, 8'h03);
      vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 2'd2, 1'b0, 8'h00, 8'h03);
      vecs[7]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 2'd2, 1'b0, 8'h00, 8'h03);
      vecs[8]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h03);
      vecs[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd3, 1'b1, 8'hA5, 8'h03);
      vecs[10] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 2'd3, 1'b1, 8'hA5, 8'h03);
      vecs[11] = mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0, 8'h00, 8'h03);
      // out-of-range address 0x20: write ignored, read returns 0x00
      vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 2'd0, 1'b0, 8'h00, 8'h03);
      vecs[13] = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 2'd1, 1'b0, 8'h00, 8'h03);
      vecs[14] = mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0, 8'h00, 8'h20);
      vecs[15] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 2'd0, 1'b0, 8'h00, 8'h20);
      vecs[16] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 2'd2, 1'b0, 8'h00, 8'h20);
      vecs[17] = mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0, 8'h00, 8'h20);
      vecs[18] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h20);
      vecs[19] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 2'd3, 1'b1, 8'h00, 8'h20);
      vecs[20] = mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0, 8'h00, 8'h20);
      // illegal: RD+WR low together, then RD low in an address phase
      vecs[21] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 2'd0, 1'b0, 8'h00, 8'h20);
      vecs[22] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 2'd0, 1'b0, 8'h00, 8'h20);
      vecs[23] = mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0, 8'h00, 8'h20);
      vecs[24] = mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0, 8'h00, 8'h20);

      // Reset state
      reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("reset rstate",       {6'b0, rstate}, 8'h00);
      chk("reset data_oe",      {7'b0, data_oe}, 8'h00);
      chk("reset AdressDatao",  AdressDatao, 8'h00);
      chk("reset addr_latched", addr_latched, 8'h00);
      reset = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < NVEC; i++) begin
         cyc(vecs[i].cs, vecs[i].ad, vecs[i].wr, vecs[i].rd, vecs[i].bus);
         chk($sformatf("vec%0d rstate", i),       {6'b0, rstate}, {6'b0, vecs[i].st});
         chk($sformatf("vec%0d data_oe", i),      {7'b0, data_oe}, {7'b0, vecs[i].oe});
         chk($sformatf("vec%0d AdressDatao", i),  AdressDatao, vecs[i].dout);
         chk($sformatf("vec%0d addr_latched", i), addr_latched, vecs[i].addr);
      end
      m_regs[3] = 8'hA5;
      read_all();

      // WRITE aborted by CS high while WR is low
      set_addr(8'h05);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'hDD);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'hDD);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hDD);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
      chk("abort rstate", {6'b0, rstate}, 8'h00);
      chk("abort addr kept", addr_latched, 8'h05);
      read_reg(8'h05, 8'h00);

      // CS and WR rising together still commits
      set_addr(8'h06);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
      m_regs[6] = 8'h3C;
      read_reg(8'h06, 8'h3C);

      // Reset pulse in the middle of a READ
      set_addr(8'h03);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("pre-reset data_oe", {7'b0, data_oe}, 8'h01);
      chk("pre-reset AdressDatao", AdressDatao, 8'hA5);
      reset = 1'b1;
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("mid-read reset data_oe", {7'b0, data_oe}, 8'h00);
      chk("mid-read reset rstate", {6'b0, rstate}, 8'h00);
      chk("mid-read reset AdressDatao", AdressDatao, 8'h00);
      chk("mid-read reset addr_latched", addr_latched, 8'h00);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
      read_all();

`ifdef RTC_RESPONDER_TICK_EN
      // Seconds 0x59 rolls to 0x00 and carries into minutes after 10 clocks.
      write_reg(8'h00, 8'h59);
      write_reg(8'h01, 8'h00);
      repeat (7) cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
      read_reg(8'h00, 8'h00);
      read_reg(8'h01, 8'h01);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rtc_bus_responder.md
RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

Interface
REQ-001 SHALL have parameter: TICK_DIV, 100, clock cycles per one-second tick when ticking is compiled in.
REQ-002 SHALL have port: clock  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port: reset  input  1  reset; it is synchronous and active-high.
REQ-004 SHALL have port: CS  input  1  chip select, active-low.
REQ-005 SHALL have port: AD  input  1  phase select; 0 = address phase, 1 = data phase.
REQ-006 SHALL have port: WR  input  1  write strobe, active-low.
REQ-007 SHALL have port: RD  input  1  read strobe, active-low.
REQ-008 SHALL have port: AdressDatai  input  8  multiplexed address/data bus from the controller.
REQ-009 SHALL have port: AdressDatao  output  8  read data returned to the controller.
REQ-010 SHALL have port: data_oe  output  1  high while AdressDatao carries valid read data.
REQ-011 SHALL have port: addr_latched  output  8  most recently committed address.
REQ-012 SHALL have port: rstate  output  2  current FSM state code.

Function
REQ-013 SHALL register CS, AD, WR, RD and AdressDatai once and use only the registered copies in FSM decisions.
REQ-014 SHALL implement FSM states IDLE=0, ADDR=1, WRITE=2, READ=3, with rstate equal to the current code.
REQ-015 SHALL, in IDLE with CS=0, enter ADDR on WR=0,AD=0; WRITE on WR=0,AD=1; READ on RD=0,AD=1.
REQ-016 SHALL stay in IDLE when RD=0 and WR=0 together, or when RD=0 with AD=0 (illegal combinations; no side effects).
REQ-017 SHALL, in ADDR or WRITE, capture the sampled bus every cycle and commit it on the first cycle WR is sampled high, then return to IDLE.
REQ-018 SHALL commit in ADDR by loading addr_latched; in WRITE by writing register[addr_latched].
REQ-019 SHALL abort with no commit if CS is sampled high while WR is still low in ADDR or WRITE; CS and WR rising in the same cycle counts as a commit.
REQ-020 SHALL implement a 16x8 register file at addresses 0x00-0x0F; writes to 0x10-0xFF are ignored.
REQ-021 SHALL hold data_oe high exactly while state is READ, i.e., from the cycle after RD=0 is sampled until the cycle after RD or CS is sampled high.
REQ-022 SHALL drive AdressDatao with register[addr_latched] while in READ, or 0x00 for addresses above 0x0F; AdressDatao SHALL be 0x00 outside READ.
REQ-023 SHALL make a write visible to a read that starts on the next cycle.
REQ-024 SHALL keep addr_latched across transactions, so consecutive data phases reuse the last address with no auto-increment.

Reset
REQ-025 SHALL, on reset, force state IDLE, all 16 registers 0x00, addr_latched 0x00, AdressDatao 0x00, data_oe 0, and tick divider 0.
REQ-026 SHALL let reset asserted mid-transaction abandon the transaction with no commit, overriding any simultaneous write or tick.

Configuration
REQ-027 SHALL compile a real-time tick only when macro RTC_RESPONDER_TICK_EN is defined.
REQ-028 SHALL, with the macro defined, increment register 0x00 (seconds, BCD) every TICK_DIV cycles.
REQ-029 SHALL, with the macro defined, roll 0x59 to 0x00 and BCD-increment register 0x01 (minutes, 0x59 to 0x00, no hour carry).
REQ-030 SHALL, with the macro defined, let a bus write to 0x00 or 0x01 in the same cycle as a tick win for that register and restart the divider.
REQ-031 SHALL, without the macro, contain no divider, and registers SHALL change only by bus writes.

Verification
REQ-032 SHALL cover: address phase 0x03 (CS=0,AD=0,WR=0 for 3 cycles, then WR=1) -> addr_latched=0x03 one cycle after WR is sampled high; rstate 0->1->0.
REQ-033 SHALL cover: write phase 0xA5 to 0x03, then read (AD=1,RD=0) -> data_oe rises one cycle after RD is sampled low; AdressDatao=0xA5; data_oe drops one cycle after RD=1.
REQ-034 SHALL cover: address 0x20, write 0x77, read -> AdressDatao=0x00; registers 0x00-0x0F unchanged.
REQ-035 SHALL cover: RD=0 and WR=0 together with CS=0 -> rstate stays 0; data_oe=0; no register changes.
REQ-036 SHALL cover: WRITE abort with CS=1 while WR=0 -> target register unchanged; then reset pulse mid-READ -> data_oe=0 and all registers 0x00 next cycle.
REQ-037 SHALL cover, with RTC_RESPONDER_TICK_EN and TICK_DIV=10: write 0x59 to 0x00 and 0x00 to 0x01 -> after 10 cycles, reg0=0x00 and reg1=0x01.
